// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared widths, FSM encoding and saturation constant for vedic_div_24by12
package div_pkg;

  // Divisor/quotient/remainder width and dividend (product) width
  localparam int DIV_N   = 12;
  localparam int DIV_A_W = 2 * DIV_N;

  // Saturated quotient returned on overflow or divide-by-zero
  localparam logic [DIV_N-1:0] SAT_ONES = {DIV_N{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/vedic_div_24by12_sub13.sv
// rtl/vedic_div_24by12_sub13.sv - (N+1)-bit trial subtractor, borrow decides the quotient bit
module sub13 #(
  parameter int W = 13
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] diff,
  output logic         borrow
);

  // One extra bit on both operands turns the MSB of the result into the borrow-out
  assign {borrow, diff} = {1'b0, x} - {1'b0, y};

endmodule

// File: rtl/vedic_div_24by12.sv
// rtl/vedic_div_24by12.sv - iterative restoring divider, 2N-bit dividend by N-bit divisor
module vedic_div_24by12
  import div_pkg::*;
#(
  parameter int N     = DIV_N,
  parameter int CNT_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   q,
  output logic [N-1:0]   r,
  output logic           ovf,
  output logic           dbz
);

  div_state_t       state;
  div_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     rem;
  logic [N-1:0]     sh;
  logic [N-1:0]     dvs;
  logic [N:0]       trial_x;
  logic [N:0]       trial_y;
  logic [N:0]       trial_diff;
  logic             trial_borrow;
  logic             accept;
  logic             unused_diff_msb;
  logic             exc;

  // Ready is forced low while reset is held so nothing is taken during reset
  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign r         = rem;
  assign exc       = ovf || dbz;

  // Partial remainder shifted left with the next dividend bit appended
  assign trial_x = {rem, sh[N-1]};
  assign trial_y = {1'b0, dvs};

  sub13 #(.W(N + 1)) u_sub (
    .x      (trial_x),
    .y      (trial_y),
    .diff   (trial_diff),
    .borrow (trial_borrow)
  );

  // rem < divisor always holds, so a non-negative difference fits in N bits
  assign unused_diff_msb = trial_diff[N];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: exceptions spend a single CALC cycle, normal operands take N iterations
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (exc || (cnt == '0)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand latch, exception decode and one restoring step per CALC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      rem <= '0;
      sh  <= '0;
      dvs <= '0;
      q   <= '0;
      ovf <= 1'b0;
      dbz <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dvs <= b;
            sh  <= a[N-1:0];
            if (b == '0) begin
              dbz <= 1'b1;
              ovf <= 1'b0;
              q   <= SAT_ONES;
              rem <= a[N-1:0];
              cnt <= '0;
            end else if (a[2*N-1:N] >= b) begin
              dbz <= 1'b0;
              ovf <= 1'b1;
              q   <= SAT_ONES;
              rem <= a[N-1:0];
              cnt <= '0;
            end else begin
              dbz <= 1'b0;
              ovf <= 1'b0;
              q   <= '0;
              rem <= a[2*N-1:N];
              cnt <= CNT_W'(N - 1);
            end
          end
        end
        CALC: begin
          if (!exc) begin
            q  <= {q[N-2:0], ~trial_borrow};
            sh <= {sh[N-2:0], 1'b0};
            if (trial_borrow) begin
              rem <= trial_x[N-1:0];
            end else begin
              rem <= trial_diff[N-1:0];
            end
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vedic_div_24by12.sv
// tb/tb_vedic_div_24by12.sv - self-checking bench for vedic_div_24by12
module tb_vedic_div_24by12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [23:0] a = '0;
  logic [11:0] b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [11:0] q;
  logic [11:0] r;
  logic        ovf;
  logic        dbz;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [23:0] a;
    logic [11:0] b;
    logic [11:0] q;
    logic [11:0] r;
    logic        ovf;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  vedic_div_24by12 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  // Called at a negedge: drive one operand pair, return at the negedge after the accept edge
  task automatic send(input logic [23:0] ta, input logic [11:0] tb_v);
    int guard;
    guard = 0;
    while (!in_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_send", in_ready, 1);
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts accept-relative edges until out_valid (0 = visible right after the accept edge)
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [11:0] bv, hi, lo, eq, er;
    logic [23:0] av;
    logic early;

    vecs[0]  = '{24'd1000,   12'd7,     12'd142,   12'd6,     1'b0, 1'b0, 12};
    vecs[1]  = '{24'h0FFFFF, 12'h100,   12'hFFF,   12'h0FF,   1'b0, 1'b0, 12};
    vecs[2]  = '{24'h123000, 12'h123,   12'hFFF,   12'h000,   1'b1, 1'b0, 1};
    vecs[3]  = '{24'h000ABC, 12'h000,   12'hFFF,   12'hABC,   1'b0, 1'b1, 1};
    vecs[4]  = '{24'h000000, 12'd5,     12'd0,     12'd0,     1'b0, 1'b0, 12};
    vecs[5]  = '{24'h000ABC, 12'd1,     12'hABC,   12'd0,     1'b0, 1'b0, 12};
    vecs[6]  = '{24'd50,     12'd5,     12'd10,    12'd0,     1'b0, 1'b0, 12};
    vecs[7]  = '{24'hFFEFFF, 12'hFFF,   12'hFFF,   12'hFFE,   1'b0, 1'b0, 12};
    vecs[8]  = '{24'h005000, 12'd5,     12'hFFF,   12'h000,   1'b1, 1'b0, 1};
    vecs[9]  = '{24'h000000, 12'h000,   12'hFFF,   12'h000,   1'b0, 1'b1, 1};
    vecs[10] = '{24'h00FFFF, 12'h010,   12'hFFF,   12'h00F,   1'b0, 1'b0, 12};
    vecs[11] = '{24'd123456, 12'd100,   12'd1234,  12'd56,    1'b0, 1'b0, 12};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_q", q, 0);
    check("rst_r", r, 0);
    check("rst_ovf", ovf, 0);
    check("rst_dbz", dbz, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].a, vecs[i].b);
      wait_valid(lat);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_q", i), q, vecs[i].q);
      check($sformatf("v%0d_r", i), r, vecs[i].r);
      check($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
      check($sformatf("v%0d_dbz", i), dbz, vecs[i].dbz);
      ack();
      check($sformatf("v%0d_valid_drop", i), out_valid, 0);
    end

    // Backpressure with a competing request held during the DONE window
    send(24'd1000, 12'd7);
    wait_valid(lat);
    check("bp_lat", lat, 12);
    a = 24'd50;
    b = 12'd5;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_q", q, 142);
      check("bp_r", r, 6);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_valid_drop", out_valid, 0);
    check("bp_ready_after_hs", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_second_accepted", in_ready, 0);
    wait_valid(lat);
    check("bp2_lat", lat, 12);
    check("bp2_q", q, 10);
    check("bp2_r", r, 0);
    ack();

    // Reset in the middle of CALC
    send(24'd1000, 12'd7);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_q", q, 0);
    check("mid_rst_r", r, 0);
    check("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    send(24'd50, 12'd5);
    wait_valid(lat);
    check("after_rst_lat", lat, 12);
    check("after_rst_q", q, 10);
    check("after_rst_r", r, 0);
    ack();

    // Randomised in-range sweep with gaps and early/late out_ready
    for (int i = 0; i < 1000; i++) begin
      bv = 12'($urandom_range(1, 4095));
      hi = 12'($urandom_range(0, int'(bv) - 1));
      lo = 12'($urandom);
      av = {hi, lo};
      eq = 12'(av / {12'd0, bv});
      er = 12'(av % {12'd0, bv});
      early = 1'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(av, bv);
      if (early) out_ready = 1'b1;
      wait_valid(lat);
      check("rnd_q", q, eq);
      check("rnd_r", r, er);
      if (early) begin
        @(negedge clk);
        out_ready = 1'b0;
      end else begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        ack();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
